uart_tx_fifo: RTL and testbench

Transmit buffer between the d16 CPU bus and the `uart` peripheral. The CPU writes bytes into a FIFO at full bus speed. A drain state machine masters the uart's bus port, polls its status register and writes one byte into the transmit register whenever the transmitter is idle. This removes per-byte busy-polling from software.

---
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - CPU-fed transmit FIFO that drains bytes into the uart bus port
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_addr,
    input  logic       i_we,
    input  logic       i_cyc,
    output logic [7:0] o_uart_dat,
    input  logic [7:0] i_uart_dat,
    output logic       o_uart_addr,
    output logic       o_uart_we,
    output logic       o_uart_cyc,
    output logic       o_int
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POLL,
        ST_WRITE,
        ST_GAP
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovf;

    logic push_req;
    logic status_rd;
    logic pop;
    logic push;
    logic full;
    logic empty;
    logic busy;
    logic tx_active;
    logic unused_uart_bits;

    assign push_req  = i_cyc & i_we & ~i_addr;
    assign status_rd = i_cyc & ~i_we & i_addr;
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign pop       = (state == ST_WRITE);
    // Fullness is judged after the same-cycle pop, so a push during WRITE is never lost.
    assign push      = push_req & (~full | pop);
    assign busy      = (state != ST_IDLE) | ~empty;
    assign tx_active = i_uart_dat[2];
    assign unused_uart_bits = ^{i_uart_dat[7:3], i_uart_dat[1:0]};

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req & ~push) begin
                ovf <= 1'b1;
            end else if (status_rd) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (!empty) state <= ST_POLL;
                ST_POLL:  if (!tx_active) state <= ST_WRITE;
                ST_WRITE: state <= ST_GAP;
                // One quiet cycle lets the uart raise tx-active before the next poll.
                ST_GAP:   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_dat = 8'd0;
        if (i_addr) begin
            o_dat = {4'd0, busy, ovf, empty, full};
        end else begin
            o_dat = 8'(count);
        end
    end

    assign o_uart_cyc  = (state == ST_POLL) | (state == ST_WRITE);
    assign o_uart_we   = (state == ST_WRITE);
    assign o_uart_addr = (state == ST_POLL);
    assign o_uart_dat  = (state == ST_WRITE) ? mem[rd_ptr] : 8'd0;
    assign o_int       = empty & (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_dat = 8'd0;
    logic [7:0] o_dat;
    logic       i_addr = 1'b0;
    logic       i_we = 1'b0;
    logic       i_cyc = 1'b0;
    logic [7:0] o_uart_dat;
    logic [7:0] i_uart_dat;
    logic       o_uart_addr;
    logic       o_uart_we;
    logic       o_uart_cyc;
    logic       o_int;
    logic       uart_busy = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         wr_cycles[$];
    int         cyc_no = 0;
    int         n_writes = 0;
    int         n_uart_cyc = 0;
    logic       model_ovf = 1'b0;

    assign i_uart_dat = {5'd0, uart_busy, 2'd0};

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_dat       (i_dat),
        .o_dat       (o_dat),
        .i_addr      (i_addr),
        .i_we        (i_we),
        .i_cyc       (i_cyc),
        .o_uart_dat  (o_uart_dat),
        .i_uart_dat  (i_uart_dat),
        .o_uart_addr (o_uart_addr),
        .o_uart_we   (o_uart_we),
        .o_uart_cyc  (o_uart_cyc),
        .o_int       (o_int)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every uart write must match the oldest byte the model accepted.
    always @(negedge i_clk) begin
        cyc_no++;
        if (o_uart_cyc) n_uart_cyc++;
        if (o_uart_cyc && o_uart_we) begin
            n_writes++;
            wr_cycles.push_back(cyc_no);
            check("write_addr", int'(o_uart_addr), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(o_uart_dat), -1);
            end else begin
                check("drain_data", int'(o_uart_dat), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_idle();
        i_cyc = 1'b0;
        i_we = 1'b0;
        i_addr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        i_cyc = 1'b1;
        i_we = 1'b1;
        i_addr = 1'b0;
        i_dat = b;
        if (exp_q.size() < 16) exp_q.push_back(b);
        else model_ovf = 1'b1;
        tick();
        bus_idle();
    endtask

    function automatic logic [7:0] model_status();
        return {4'd0, exp_q.size() != 0, model_ovf, exp_q.size() == 0, exp_q.size() == 16};
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || !o_int); i++) tick();
        check("drain_empty", exp_q.size(), 0);
        check("drain_int", int'(o_int), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int w0;
        int c0;
        int sent;
        int max_cnt;
        int wr_pushes;
        logic all_poll;

        // Reset held for two edges.
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        i_addr = 1'b1;
        #1;
        check("reset_status", int'(o_dat), 8'h02);
        i_addr = 1'b0;
        #1;
        check("reset_count", int'(o_dat), 0);
        check("reset_int", int'(o_int), 1);
        check("reset_uart_cyc", int'(o_uart_cyc), 0);

        // Single byte, uart idle.
        uart_busy = 1'b0;
        push(8'hA5);
        check("single_int_drop", int'(o_int), 0);
        check("single_c1_idle", int'(o_uart_cyc), 0);
        tick();
        check("single_c2_poll", int'({o_uart_cyc, o_uart_we, o_uart_addr}), 3'b101);
        tick();
        check("single_c3_write", int'({o_uart_cyc, o_uart_we, o_uart_addr}), 3'b110);
        check("single_c3_dat", int'(o_uart_dat), 8'hA5);
        tick();
        check("single_c4_gap", int'(o_uart_cyc), 0);
        check("single_c4_int", int'(o_int), 0);
        tick();
        check("single_c5_int", int'(o_int), 1);

        // Busy uart: continuous polling, no writes until released.
        uart_busy = 1'b1;
        w0 = n_writes;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        all_poll = 1'b1;
        repeat (20) begin
            if (!(o_uart_cyc && !o_uart_we && o_uart_addr)) all_poll = 1'b0;
            tick();
        end
        check("busy_all_poll", int'(all_poll), 1);
        check("busy_no_write", n_writes - w0, 0);
        check("busy_count", int'(o_dat), 3);
        wr_cycles.delete();
        uart_busy = 1'b0;
        wait_drain();
        check("busy_nbytes", wr_cycles.size(), 3);
        for (int i = 1; i < wr_cycles.size(); i++)
            check("busy_spacing", wr_cycles[i] - wr_cycles[i-1], 4);

        // Overflow: 17 pushes into a 16-deep FIFO with the uart held busy.
        uart_busy = 1'b1;
        model_ovf = 1'b0;
        w0 = n_writes;
        for (int i = 0; i <= 16; i++) push(8'(i));
        i_cyc = 1'b1;
        i_addr = 1'b1;
        #1;
        check("ovf_status", int'(o_dat), int'(model_status()));
        check("ovf_full_bit", int'(o_dat[0]), 1);
        tick();
        model_ovf = 1'b0;
        check("ovf_cleared_status", int'(o_dat), int'(model_status()));
        bus_idle();
        #1;
        check("ovf_count", int'(o_dat), 16);
        uart_busy = 1'b0;
        wait_drain();
        check("ovf_nbytes", n_writes - w0, 16);

        // Streaming across pointer wrap, pushing in WRITE cycles as well.
        w0 = n_writes;
        sent = 0;
        max_cnt = 0;
        wr_pushes = 0;
        for (int cyc = 0; cyc < 2000 && (sent < 40 || exp_q.size() != 0); cyc++) begin
            uart_busy = ($urandom_range(0, 3) == 0);
            if (int'(o_dat) > max_cnt) max_cnt = int'(o_dat);
            if (sent < 40 && exp_q.size() < 15 && (o_uart_we || $urandom_range(0, 2) == 0)) begin
                if (o_uart_we) wr_pushes++;
                sent++;
                push(8'($urandom));
            end else begin
                tick();
            end
        end
        uart_busy = 1'b0;
        wait_drain();
        check("stream_sent", sent, 40);
        check("stream_nbytes", n_writes - w0, 40);
        check("stream_max_le16", int'(max_cnt <= 16), 1);
        check("stream_write_pushes", int'(wr_pushes > 0), 1);

        // Reset while polling with 5 bytes queued.
        uart_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'($urandom));
        for (int i = 0; i < 20 && !(o_uart_cyc && !o_uart_we); i++) tick();
        check("rst_in_poll", int'({o_uart_cyc, o_uart_we, o_uart_addr}), 3'b101);
        i_reset = 1'b1;
        exp_q.delete();
        model_ovf = 1'b0;
        tick();
        i_reset = 1'b0;
        check("rst_uart_cyc", int'(o_uart_cyc), 0);
        check("rst_int", int'(o_int), 1);
        check("rst_count", int'(o_dat), 0);
        i_addr = 1'b1;
        #1;
        check("rst_status", int'(o_dat), 8'h02);
        i_addr = 1'b0;
        uart_busy = 1'b0;
        c0 = n_uart_cyc;
        repeat (20) tick();
        check("rst_no_uart_cycles", n_uart_cyc - c0, 0);
        check("rst_int_after", int'(o_int), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
